// File: rtl/nes_bus_pkg.sv
// Address map, DMA state encoding and region decode shared by the CPU bus responder
// and its OAM DMA engine.
package nes_bus_pkg;

   localparam logic [15:0] RAM_LIMIT    = 16'h1FFF;
   localparam logic [15:0] PPU_LIMIT    = 16'h3FFF;
   localparam logic [15:0] IO_LIMIT     = 16'h7FFF;
   localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
   localparam logic [2:0]  PPU_OAMDATA  = 3'd4;
   // Bus address the DMA writes to: first PPU register mirror, OAMDATA slot.
   localparam logic [15:0] OAMDATA_ADDR = 16'h2000 | {13'd0, PPU_OAMDATA};

   typedef enum logic [2:0] {
      DMA_IDLE,
      DMA_HALT,
      DMA_ALIGN,
      DMA_RD,
      DMA_WR
   } dma_state_t;

   typedef enum logic [1:0] {
      RGN_RAM,
      RGN_PPU,
      RGN_IO,
      RGN_PRG
   } region_t;

   function automatic region_t decode_region(input logic [15:0] addr);
      if (addr <= RAM_LIMIT)      return RGN_RAM;
      else if (addr <= PPU_LIMIT) return RGN_PPU;
      else if (addr <= IO_LIMIT)  return RGN_IO;
      else                        return RGN_PRG;
   endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: halts the CPU, optionally burns one cycle to align to parity, then
// copies one 256-byte page into OAMDATA as alternating read/write cycles.
module oam_dma
   import nes_bus_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic [7:0]  page_i,
   input  logic [7:0]  rdata_i,
   output dma_state_t  state_o,
   output logic [15:0] m_addr_o,
   output logic        m_write_o,
   output logic [7:0]  m_wdata_o
);

   dma_state_t state_q, state_d;
   logic       parity_q;
   logic [7:0] page_q, page_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] buf_q, buf_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= DMA_IDLE;
         parity_q <= 1'b0;
         page_q   <= '0;
         idx_q    <= '0;
         buf_q    <= '0;
      end else begin
         state_q  <= state_d;
         parity_q <= ~parity_q;
         page_q   <= page_d;
         idx_q    <= idx_d;
         buf_q    <= buf_d;
      end
   end

   // HALT and ALIGN issue harmless dummy reads of the first source byte.
   always_comb begin
      state_d   = state_q;
      page_d    = page_q;
      idx_d     = idx_q;
      buf_d     = buf_q;
      m_addr_o  = {page_q, idx_q};
      m_write_o = 1'b0;
      m_wdata_o = buf_q;
      case (state_q)
         DMA_IDLE: begin
            if (start_i) begin
               state_d = DMA_HALT;
               page_d  = page_i;
               idx_d   = '0;
            end
         end
         DMA_HALT:  state_d = parity_q ? DMA_ALIGN : DMA_RD;
         DMA_ALIGN: state_d = DMA_RD;
         DMA_RD: begin
            buf_d   = rdata_i;
            state_d = DMA_WR;
         end
         DMA_WR: begin
            m_addr_o  = OAMDATA_ADDR;
            m_write_o = 1'b1;
            idx_d     = idx_q + 8'd1;
            state_d   = (idx_q == 8'hFF) ? DMA_IDLE : DMA_RD;
         end
         default: state_d = DMA_IDLE;
      endcase
   end

   assign state_o = state_q;

endmodule

// File: rtl/cpu_bus.sv
// CPU-side bus responder: decodes the current bus master's address, returns read data
// combinationally, owns work RAM and the open-bus latch, and hosts the OAM DMA engine.
module cpu_bus
   import nes_bus_pkg::*;
#(
   parameter int RAM_AW = 11,
   parameter int PRG_AW = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       cpu_addr,
   input  logic              cpu_write,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ready,
   output logic              ppu_cs,
   output logic              ppu_we,
   output logic [2:0]        ppu_addr,
   output logic [7:0]        ppu_wdata,
   input  logic [7:0]        ppu_rdata,
   output logic [PRG_AW-1:0] prg_addr,
   input  logic [7:0]        prg_rdata
);

   dma_state_t  dma_state;
   logic        dma_busy;
   logic        dma_start;
   logic [15:0] dma_addr;
   logic        dma_write;
   logic [7:0]  dma_wdata;
   logic [15:0] m_addr;
   logic        m_write;
   logic [7:0]  m_wdata;
   logic [7:0]  rd_data;
   logic [7:0]  openbus_q;
   region_t     rgn;
   logic [7:0]  ram_q [2**RAM_AW];

   // cpu_ready low means the CPU's address, write strobe and data are ignored this cycle.
   assign cpu_ready = (dma_state == DMA_IDLE);
   assign dma_busy  = ~cpu_ready;
   assign dma_start = cpu_ready && cpu_write && (cpu_addr == OAMDMA_ADDR);

   oam_dma u_oam_dma (
      .clk       (clk),
      .reset     (reset),
      .start_i   (dma_start),
      .page_i    (cpu_wdata),
      .rdata_i   (rd_data),
      .state_o   (dma_state),
      .m_addr_o  (dma_addr),
      .m_write_o (dma_write),
      .m_wdata_o (dma_wdata)
   );

   assign m_addr  = dma_busy ? dma_addr  : cpu_addr;
   assign m_write = dma_busy ? dma_write : cpu_write;
   assign m_wdata = dma_busy ? dma_wdata : cpu_wdata;
   assign rgn     = decode_region(m_addr);

   always_comb begin
      rd_data = openbus_q;
      case (rgn)
         RGN_RAM: rd_data = ram_q[m_addr[RAM_AW-1:0]];
         RGN_PPU: rd_data = ppu_rdata;
         RGN_PRG: rd_data = prg_rdata;
         default: rd_data = openbus_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (m_write && (rgn == RGN_RAM)) ram_q[m_addr[RAM_AW-1:0]] <= m_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         openbus_q <= '0;
      else if (!m_write) openbus_q <= rd_data;
   end

   assign cpu_rdata = dma_busy ? openbus_q : rd_data;
   assign ppu_cs    = (rgn == RGN_PPU);
   assign ppu_we    = ppu_cs && m_write;
   assign ppu_addr  = m_addr[2:0];
   assign ppu_wdata = ppu_cs ? m_wdata : 8'h00;
   assign prg_addr  = m_addr[PRG_AW-1:0];

endmodule

// File: tb/tb_cpu_bus.sv
// Randomized bench for cpu_bus: a behavioural model of the address map, open bus and
// OAM DMA (page snapshot, stall length from parity) scores every observed cycle.
module tb_cpu_bus;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cpu_addr;
   logic        cpu_write;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_ready;
   logic        ppu_cs;
   logic        ppu_we;
   logic [2:0]  ppu_addr;
   logic [7:0]  ppu_wdata;
   logic [7:0]  ppu_rdata;
   logic [14:0] prg_addr;
   logic [7:0]  prg_rdata;

   always #5 clk = ~clk;

   cpu_bus #(.RAM_AW(11), .PRG_AW(15)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_addr  (cpu_addr),
      .cpu_write (cpu_write),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .ppu_cs    (ppu_cs),
      .ppu_we    (ppu_we),
      .ppu_addr  (ppu_addr),
      .ppu_wdata (ppu_wdata),
      .ppu_rdata (ppu_rdata),
      .prg_addr  (prg_addr),
      .prg_rdata (prg_rdata)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  ref_ram [0:2047];
   logic [7:0]  ob;
   logic [31:0] cyc;
   logic [7:0]  exp_q [$];

   // Clock count since reset release; its LSB is the parity the DUT should hold.
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_read(input logic [15:0] a, input logic [7:0] pp,
                                             input logic [7:0] pr);
      if (a < 16'h2000)      return ref_ram[a[10:0]];
      else if (a < 16'h4000) return pp;
      else if (a < 16'h8000) return ob;
      else                   return pr;
   endfunction

   function automatic logic [15:0] rand_addr();
      logic [15:0] a;
      int sel;
      sel = $urandom_range(0, 3);
      case (sel)
         0: a = 16'($urandom_range(0, 16'h1FFF));
         1: a = 16'h2000 | 16'($urandom_range(0, 16'h1FFF));
         2: begin
            a = 16'h4000 | 16'($urandom_range(0, 16'h3FFF));
            if (a == 16'h4014) a = 16'h4015;
         end
         default: a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
      endcase
      return a;
   endfunction

   // One CPU cycle, entered and left at a falling edge.
   task automatic bus_cycle(input logic [15:0] a, input logic w, input logic [7:0] d,
                            input logic [7:0] pp, input logic [7:0] pr);
      logic [7:0] exp_rd;
      logic       in_ppu;
      cpu_addr  = a;
      cpu_write = w;
      cpu_wdata = d;
      ppu_rdata = pp;
      prg_rdata = pr;
      #1;
      in_ppu = (a >= 16'h2000) && (a < 16'h4000);
      exp_rd = model_read(a, pp, pr);
      check_eq("ready", cpu_ready, 1);
      if (!w) check_eq("rdata", cpu_rdata, exp_rd);
      check_eq("ppu_cs", ppu_cs, in_ppu);
      check_eq("ppu_we", ppu_we, in_ppu && w);
      check_eq("ppu_addr", ppu_addr, a[2:0]);
      if (!in_ppu)  check_eq("ppu_wdata_idle", ppu_wdata, 0);
      else if (w)   check_eq("ppu_wdata", ppu_wdata, d);
      check_eq("prg_addr", prg_addr, a[14:0]);
      @(posedge clk);
      if (!w)                ob = exp_rd;
      else if (a < 16'h2000) ref_ram[a[10:0]] = d;
      @(negedge clk);
   endtask

   // Starts a DMA whose HALT cycle sees halt_par; abort_at>0 resets after that many OAM writes.
   task automatic run_dma(input logic [7:0] page, input logic halt_par, input logic poke,
                          input int abort_at);
      int         stall;
      int         pulses;
      logic [7:0] last;
      logic [7:0] poke_val;
      exp_q.delete();
      for (int i = 0; i < 256; i++) exp_q.push_back(ref_ram[{page[2:0], 8'(i)}]);
      last = exp_q[255];
      if (cyc[0] == halt_par) bus_cycle(16'h8000, 1'b0, 8'h00, 8'h00, 8'($urandom));
      cpu_addr  = 16'h4014;
      cpu_write = 1'b1;
      cpu_wdata = page;
      #1;
      check_eq("dma_start_ready", cpu_ready, 1);
      @(posedge clk);
      @(negedge clk);
      stall    = 0;
      pulses   = 0;
      poke_val = ~ref_ram[11'h300];
      for (int c = 0; c < 600; c++) begin
         if (poke && c == 20) begin
            cpu_addr  = 16'h0300;
            cpu_write = 1'b1;
            cpu_wdata = poke_val;
         end else begin
            cpu_addr  = 16'h4000;
            cpu_write = 1'b0;
            cpu_wdata = 8'($urandom);
         end
         ppu_rdata = 8'($urandom);
         prg_rdata = 8'($urandom);
         #1;
         if (cpu_ready) break;
         stall++;
         if (ppu_we) begin
            pulses++;
            check_eq("oam_addr", ppu_addr, 4);
            check_eq("oam_cs", ppu_cs, 1);
            if (exp_q.size() > 0) check_eq("oam_data", ppu_wdata, exp_q.pop_front());
            else                  check_eq("oam_extra_pulse", pulses, 256);
            if (abort_at != 0 && pulses == abort_at) begin
               reset = 1'b1;
               #1;
               check_eq("abort_ready", cpu_ready, 1);
               check_eq("abort_we", ppu_we, 0);
               @(posedge clk);
               @(negedge clk);
               reset = 1'b0;
               ob    = 8'h00;
               return;
            end
         end
         @(negedge clk);
      end
      check_eq("ready_after", cpu_ready, 1);
      check_eq("dma_stall", stall, 513 + int'(halt_par));
      check_eq("dma_pulses", pulses, 256);
      check_eq("openbus_after_dma", cpu_rdata, last);
      @(posedge clk);
      ob = last;
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] pg;
      reset     = 1'b1;
      cpu_addr  = 16'hC123;
      cpu_write = 1'b0;
      cpu_wdata = 8'h00;
      ppu_rdata = 8'h00;
      prg_rdata = 8'h11;
      ob        = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ready", cpu_ready, 1);
      check_eq("rst_ppu_cs", ppu_cs, 0);
      check_eq("rst_ppu_we", ppu_we, 0);
      check_eq("rst_ppu_wdata", ppu_wdata, 0);
      check_eq("rst_ppu_addr", ppu_addr, 3);
      check_eq("rst_prg_addr", prg_addr, 15'h4123);
      check_eq("rst_rdata", cpu_rdata, 8'h11);
      reset = 1'b0;

      for (int i = 0; i < 2048; i++) bus_cycle(16'(i), 1'b1, 8'($urandom), 8'h00, 8'h00);

      bus_cycle(16'h0005, 1'b1, 8'hA5, 8'($urandom), 8'($urandom));
      bus_cycle(16'h0805, 1'b0, 8'h00, 8'($urandom), 8'($urandom));
      bus_cycle(16'h1805, 1'b0, 8'h00, 8'($urandom), 8'($urandom));
      bus_cycle(16'hC123, 1'b0, 8'h00, 8'($urandom), 8'h4C);
      bus_cycle(16'h5000, 1'b0, 8'h00, 8'($urandom), 8'($urandom));
      bus_cycle(16'h3FFE, 1'b1, 8'h3C, 8'($urandom), 8'($urandom));
      bus_cycle(16'h8000, 1'b0, 8'h00, 8'($urandom), 8'($urandom));

      for (int i = 0; i < 500; i++)
         bus_cycle(rand_addr(), ($urandom_range(0, 2) == 0), 8'($urandom),
                   8'($urandom), 8'($urandom));

      for (int i = 0; i < 256; i++) bus_cycle(16'h0200 + 16'(i), 1'b1, 8'(i) ^ 8'h5A, 8'h00, 8'h00);

      run_dma(8'h02, 1'b0, 1'b1, 0);
      bus_cycle(16'h0300, 1'b0, 8'h00, 8'($urandom), 8'($urandom));
      run_dma(8'h02, 1'b1, 1'b1, 0);
      bus_cycle(16'h0300, 1'b0, 8'h00, 8'($urandom), 8'($urandom));

      for (int i = 0; i < 50; i++)
         bus_cycle(rand_addr(), ($urandom_range(0, 2) == 0), 8'($urandom),
                   8'($urandom), 8'($urandom));

      pg = 8'($urandom_range(0, 7));
      run_dma(pg, 1'($urandom_range(0, 1)), 1'b0, 100);
      for (int i = 0; i < 4; i++) bus_cycle(16'h8000, 1'b0, 8'h00, 8'h00, 8'($urandom));
      pg = 8'($urandom_range(0, 7));
      run_dma(pg, 1'($urandom_range(0, 1)), 1'b0, 0);
      for (int i = 0; i < 20; i++)
         bus_cycle(rand_addr(), ($urandom_range(0, 2) == 0), 8'($urandom),
                   8'($urandom), 8'($urandom));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cpu_bus.md
Name: cpu_bus

Overview:
Bus responder on the far side of the 6502-style cpu core's memory interface. It decodes the CPU address and returns read data combinationally in the same cycle, so the core can sample d_in on the same clock it drives addr. It owns the 2 KB internal work RAM, forwards PPU register and PRG ROM accesses, and contains the OAM DMA engine at $4014, which stalls the CPU through ready.

Parameters:
RAM_AW, 11, work RAM address width (mirrored through $0000-$1FFF)
PRG_AW, 15, PRG ROM address width (mirrored through $8000-$FFFF)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
cpu_addr  input  16  CPU address (cpu.addr)
cpu_write  input  1  CPU write strobe (cpu.write)
cpu_wdata  input  8  CPU write data (cpu.d_out)
cpu_rdata  output  8  read data to CPU (cpu.d_in), combinational
cpu_ready  output  1  CPU ready; low while DMA owns the bus
ppu_cs  output  1  PPU register access this cycle
ppu_we  output  1  PPU register write
ppu_addr  output  3  PPU register index
ppu_wdata  output  8  PPU write data
ppu_rdata  input  8  PPU read data, combinational
prg_addr  output  PRG_AW  PRG ROM address
prg_rdata  input  8  PRG ROM data, combinational

Behaviour:
- Bus master: the CPU in IDLE; otherwise the DMA. Master signals are m_addr, m_write, m_wdata.
- Address map, decoded from m_addr:
  - $0000-$1FFF: RAM[m_addr[RAM_AW-1:0]]. Read is asynchronous. Write takes effect at posedge when m_write=1.
  - $2000-$3FFF: ppu_cs=1, ppu_addr=m_addr[2:0], ppu_we=m_write, read data=ppu_rdata.
  - $4014: write starts DMA (page=cpu_wdata). Read returns open bus.
  - $4000-$7FFF except $4014: read returns open bus. Writes are ignored.
  - $8000-$FFFF: prg_addr=m_addr[PRG_AW-1:0], read data=prg_rdata. Writes are ignored.
- prg_addr is driven from m_addr[PRG_AW-1:0] every cycle. ppu_cs, ppu_we and ppu_wdata are 0 outside the PPU window.
- Open-bus latch: updated at every posedge with the selected read data when the cycle is a read. It holds on write cycles. Reset value $00.
- cpu_rdata = selected read data. During DMA, cpu_rdata = open-bus latch.
- CPU writes while cpu_ready=0 are ignored (masked).
- Parity flop: toggles every clock. Reset value 0.
- DMA FSM states: IDLE, HALT, ALIGN, RD, WR.
  - IDLE -> HALT at the posedge where cpu_write=1 and cpu_addr=$4014. Latch page; idx=0.
  - HALT (1 cycle) -> ALIGN if parity=1, else RD.
  - ALIGN (1 cycle) -> RD.
  - RD: m_addr={page,idx}, m_write=0. At posedge, buf<=read data; -> WR.
  - WR: ppu_cs=1, ppu_we=1, ppu_addr=3'd4 (OAMDATA), ppu_wdata=buf. At posedge idx<=idx+1 (8-bit wrap). If idx==$FF -> IDLE, else -> RD.
- cpu_ready = (state==IDLE). Stall length is 513 cycles from even parity and 514 from odd.
- A DMA source page in the PPU window reads PPU registers (side effects allowed). A source page in $40-$7F yields open-bus data.
- Reset (async): state=IDLE, cpu_ready=1, parity=0, open bus=$00, idx=0, buf=$00. RAM contents are not cleared. A DMA in progress aborts immediately with no further ppu_we.
- Reset values of outputs: cpu_ready=1, ppu_cs=0, ppu_we=0, ppu_wdata=$00. cpu_rdata, ppu_addr and prg_addr follow cpu_addr.

Decomposition:
- Package nes_bus_pkg holds:
  - region base/limit constants
  - OAMDMA_ADDR=$4014
  - PPU_OAMDATA=3'd4
  - dma_state_t enum (IDLE, HALT, ALIGN, RD, WR)
- Sub-module oam_dma holds the FSM, parity, page/idx/buf and outputs master-select plus m_addr/ppu strobes.
- cpu_bus holds the decoder, RAM array, open-bus latch and muxing.

Test Plan:
- RAM mirror: write $0005=$A5; read $0805, then $1805 -> cpu_rdata=$A5 in the same cycle as the address.
- PRG mirror: addr $C123 with prg_rdata=$4C -> prg_addr=$4123, cpu_rdata=$4C. Next cycle, read $5000 -> cpu_rdata=$4C (open bus).
- PPU mirror: write $3FFE=$3C -> ppu_cs=1, ppu_we=1, ppu_addr=6, ppu_wdata=$3C, for one cycle only.
- DMA even: RAM $0200+i = i^$5A; write $4014=$02 with parity=0.
  - cpu_ready low for exactly 513 cycles.
  - Exactly 256 ppu_we pulses, ppu_addr=4, data i^$5A in order i=0..255.
  - cpu_ready high on the next cycle.
- DMA odd: same stimulus started with parity=1 -> 514-cycle stall, identical data sequence. A CPU write to $0300 during the stall leaves RAM unchanged.
- Reset mid-DMA: assert reset after the 100th ppu_we.
  - cpu_ready=1 asynchronously; no further ppu_we.
  - Next $4014 write runs a full 256-byte transfer.
